// File: rtl/dmem_responder_if.sv
// dmem_responder_if
// Processor-side data-memory port of dmem_responder.
//   req, wren          : access request and direction (1 = store)
//   address_dmem, data : byte address and store data
//   access_type        : RISC-V funct3 load/store width code
//   q_dmem             : formatted load result
//   busy, done         : access in flight / one-cycle completion pulse
//   misaligned         : one-cycle rejection pulse (trap build only)
// master = processor, slave = responder.
interface dmem_responder_if;
    logic        req;
    logic        wren;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic [2:0]  access_type;
    logic [31:0] q_dmem;
    logic        busy;
    logic        done;
    logic        misaligned;

    modport master (
        output req, wren, address_dmem, data, access_type,
        input  q_dmem, busy, done, misaligned
    );

    modport slave (
        input  req, wren, address_dmem, data, access_type,
        output q_dmem, busy, done, misaligned
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
// Bridges the processor data-memory port to a single-port synchronous word
// RAM (one-cycle read latency). Loads are lane-selected and sign/zero
// extended; byte/halfword stores are done as read-modify-write.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   bus          : processor port (dmem_responder_if.slave)
//   ram_addr     : RAM word address (address_dmem[RAM_AW+1:2])
//   ram_wen      : RAM write enable
//   ram_din      : RAM write data
//   ram_dout     : RAM read data, valid the cycle after ram_addr
// Build option: define DMEM_MISALIGN_TRAP_EN to reject misaligned halfword
// and word accesses with a misaligned pulse instead of truncating the
// offending low address bits.
//
// state   | meaning
// IDLE    | accepting requests; word stores complete here
// LD_WAIT | RAM read data present, load result formatted this cycle
// RMW_RD  | RAM word present, merge store lane(s) into it
// RMW_WR  | write merged word back
module dmem_responder #(
    parameter int RAM_AW = 12
) (
    input  logic              clock,
    input  logic              reset,
    dmem_responder_if.slave   bus,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_wen,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LD_WAIT = 2'd1;
    localparam logic [1:0] ST_RMW_RD  = 2'd2;
    localparam logic [1:0] ST_RMW_WR  = 2'd3;

    logic [1:0]        state;
    logic [RAM_AW-1:0] addr_q;
    logic [1:0]        lane_q;
    logic [2:0]        type_q;
    logic [15:0]       data_q;
    logic [31:0]       merged_q;
    logic [31:0]       q_hold;
    logic              done_q;
    logic              mis_q;

    logic              in_word;
    logic              in_half;
    logic              misalign_hit;
    logic [RAM_AW-1:0] in_idx;
    logic              unused_addr_bits;

    // Width decode: funct3[1] set means word (covers 010 and the
    // undefined codes 011/110/111); otherwise funct3[0] picks half vs byte.
    assign in_word = bus.access_type[1];
    assign in_half = !bus.access_type[1] && bus.access_type[0];
    assign in_idx  = bus.address_dmem[RAM_AW+1:2];
    assign unused_addr_bits = ^bus.address_dmem[31:RAM_AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign_hit = (in_half && bus.address_dmem[0]) ||
                          (in_word && (bus.address_dmem[1:0] != 2'b00));
`else
    assign misalign_hit = 1'b0;
`endif

    function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  t);
        logic [15:0] half;
        logic [7:0]  byte_v;
        half = lane[1] ? word[31:16] : word[15:0];
        case (lane)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        if (t[1])
            fmt_load = word;
        else if (t[0])
            fmt_load = t[2] ? {16'h0000, half} : {{16{half[15]}}, half};
        else
            fmt_load = t[2] ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  t,
                                                input logic [15:0] d);
        logic [31:0] m;
        m = word;
        if (t[0]) begin
            if (lane[1]) m[31:16] = d;
            else         m[15:0]  = d;
        end else begin
            case (lane)
                2'd0:    m[7:0]   = d[7:0];
                2'd1:    m[15:8]  = d[7:0];
                2'd2:    m[23:16] = d[7:0];
                default: m[31:24] = d[7:0];
            endcase
        end
        merge_store = m;
    endfunction

    // RAM side is combinational so the read issues in the request cycle.
    // Held at zero while in reset so an aborted RMW can never write.
    always_comb begin
        ram_addr = '0;
        ram_wen  = 1'b0;
        ram_din  = '0;
        if (reset) begin
            case (state)
                ST_IDLE: begin
                    if (bus.req && !misalign_hit) begin
                        ram_addr = in_idx;
                        if (bus.wren && in_word) begin
                            ram_wen = 1'b1;
                            ram_din = bus.data;
                        end
                    end
                end
                ST_RMW_WR: begin
                    ram_addr = addr_q;
                    ram_wen  = 1'b1;
                    ram_din  = merged_q;
                end
                default: ram_addr = addr_q;
            endcase
        end
    end

    // Load data is valid in LD_WAIT straight off the RAM; afterwards the
    // registered copy holds it until the next load.
    assign bus.q_dmem     = (state == ST_LD_WAIT) ? fmt_load(ram_dout, lane_q, type_q) : q_hold;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = done_q;
    assign bus.misaligned = mis_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            lane_q   <= 2'b00;
            type_q   <= 3'b000;
            data_q   <= 16'h0000;
            merged_q <= 32'h0;
            q_hold   <= 32'h0;
            done_q   <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            mis_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        if (misalign_hit) begin
                            mis_q <= 1'b1;
                        end else begin
                            addr_q <= in_idx;
                            lane_q <= bus.address_dmem[1:0];
                            type_q <= bus.access_type;
                            data_q <= bus.data[15:0];
                            if (!bus.wren) begin
                                // done lines up with LD_WAIT, the cycle the result is valid
                                done_q <= 1'b1;
                                state  <= ST_LD_WAIT;
                            end else if (in_word) begin
                                done_q <= 1'b1;
                            end else begin
                                state <= ST_RMW_RD;
                            end
                        end
                    end
                end
                ST_LD_WAIT: begin
                    q_hold <= fmt_load(ram_dout, lane_q, type_q);
                    state  <= ST_IDLE;
                end
                ST_RMW_RD: begin
                    merged_q <= merge_store(ram_dout, lane_q, type_q, data_q);
                    done_q   <= 1'b1;
                    state    <= ST_RMW_WR;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder sitting between the processor's data-memory port and a single-port synchronous word RAM. It decodes the RISC-V load/store width carried on `access_type`. It performs byte-lane selection with sign/zero extension for loads, and read-modify-write for byte and halfword stores. It reports completion with a one-cycle `done` pulse and holds `busy` while an access is in flight.

## Interface

Parameters:
- `RAM_AW`, default 12: RAM word-address width. The RAM index is `address_dmem[RAM_AW+1:2]`.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in 1: access request. Sampled only in IDLE.
- `wren` in 1: 1 = store, 0 = load. Qualified by `req`.
- `address_dmem` in 32: byte address.
- `data` in 32: store data. Sub-word stores use the low bits.
- `access_type` in 3: RISC-V funct3 encoding.
  - 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
  - Other codes are treated as W.
- `q_dmem` out 32: formatted load result. Held until the next load completes.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when an access completes.
- `misaligned` out 1: one-cycle pulse when a request is rejected (see Configuration).
- `ram_addr` out RAM_AW: RAM word address.
- `ram_wen` out 1: RAM write enable.
- `ram_din` out 32: RAM write data.
- `ram_dout` in 32: RAM read data, valid one cycle after the address is presented.

## Operation

States:
- IDLE
- LD_WAIT
- RMW_RD
- RMW_WR

Transitions on each rising edge:
- IDLE with `req`=1 and `wren`=0:
  - Drive `ram_addr`; go to LD_WAIT.
- IDLE with `req`=1, `wren`=1, and access_type W:
  - Drive `ram_addr`, `ram_din=data`, `ram_wen=1` combinationally in the same cycle.
  - Register `done`=1; stay in IDLE.
- IDLE with `req`=1, `wren`=1, and access_type B or H:
  - Drive `ram_addr` and latch address, data and type; go to RMW_RD.
- LD_WAIT:
  - Format `ram_dout` into `q_dmem`, pulse `done`, return to IDLE.
- RMW_RD:
  - Merge latched data into `ram_dout`; go to RMW_WR.
- RMW_WR:
  - Assert `ram_wen` with the merged word, pulse `done`, return to IDLE.

Lane rules (little-endian):
- Byte lane is `address_dmem[1:0]`; lane k occupies bits 8k+7:8k.
- A halfword uses lane pair `address_dmem[1]` (bits 15:0 or 31:16).
- Loads:
  - B/H are sign-extended from the selected lane.
  - BU/HU are zero-extended.
  - W passes the word through unchanged.
- RMW merge replaces only the selected lane(s). All other bits keep their `ram_dout` values.

Other rules:
- `req` while `busy`=1 is ignored. The processor holds its request until `done`.
- A new `req` is accepted in IDLE in the same cycle that `done` is high.
- `ram_wen` is never asserted outside IDLE-word-store and RMW_WR.

## Timing

Reset values:
- State is IDLE.
- `q_dmem`, `done`, `misaligned`, `busy`, `ram_wen`, `ram_addr` and `ram_din` are all 0.

Latency, counted from the `req` cycle C:
- Load: `done` and valid `q_dmem` in cycle C+1.
- Word store: RAM written at the edge ending cycle C; `done` in cycle C+1.
- Sub-word store: RAM read in cycle C; merged write during cycle C+2; `done` in cycle C+2. The RAM is updated at the edge ending C+2.

Reset mid-operation:
- Reset asserted at any point returns to IDLE immediately.
- A reset during RMW_RD or RMW_WR, before the write edge, leaves the RAM word unmodified.
- No `done` is emitted for an aborted access.

## Configuration

Macro `DMEM_MISALIGN_TRAP_EN`.

Defined:
- A halfword with `address_dmem[0]`=1, or a word with `address_dmem[1:0]`≠0, is rejected.
- On rejection: pulse `misaligned` in cycle C+1, make no RAM access, no `done`, and leave `q_dmem` unchanged.
- The state stays IDLE.

Undefined:
- Offending low address bits are ignored: halfword uses bit 1 only; word forces lane 0.
- `misaligned` is tied to 0.

## Test plan

- Word store then load: SW 0x11223344 to 0x4 → RAM[1]=0x11223344; LW 0x4 → `q_dmem`=0x11223344 with `done` at C+1.
- Byte store RMW: RAM[1]=0x11223344; SB data=0xAB at 0x5 → RAM[1]=0x1122AB44; `busy` high for C+1..C+2; `done` at C+2.
- Sign/zero extension: RAM[2]=0x8000_7F80.
  - LB 0x8 → 0xFFFFFF80
  - LBU 0x8 → 0x00000080
  - LH 0xA → 0xFFFF8000
  - LHU 0xA → 0x00008000
- Halfword store to the upper lane: RAM[3]=0xDEADBEEF; SH data=0x1234 at 0xE → RAM[3]=0x1234BEEF.
- Reset mid-RMW: SB 0xFF at 0x4 over 0x11223344; pull `reset` low during RMW_RD → RAM[1] stays 0x11223344, outputs 0, state IDLE, no `done`.
- With `DMEM_MISALIGN_TRAP_EN`: LW at 0x2 → `misaligned` pulse at C+1, no `done`, `ram_wen`=0.
- Without `DMEM_MISALIGN_TRAP_EN`: LW at 0x2 → returns RAM[0].
